poly_byte_encode12: RTL

//  Transmit-side counterpart of the parse block: packs a polynomial of N 12-bit

---
 rtl/poly_byte_encode12.sv | 97 +++++++++
 1 files changed

// File: rtl/poly_byte_encode12.sv
// Packs pairs of 12-bit coefficients, each reduced once mod Q, into a little-endian
// 3-byte stream (ByteEncode_12). One pair is loaded, then its three bytes are emitted.
module poly_byte_encode12 #(
  parameter int unsigned N = 256,
  parameter int unsigned Q = 3329
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] coeff_in,
  input  logic        coeff_valid,
  output logic        coeff_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PW = (N / 2 > 1) ? $clog2(N / 2) : 1;
  localparam logic [PW-1:0] LAST_PAIR = PW'(N / 2 - 1);
  localparam logic [11:0] QV = 12'(Q);

  typedef enum logic [2:0] {
    IDLE, LOAD0, LOAD1, EMIT0, EMIT1, EMIT2, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pair_cnt_q, pair_cnt_d;
  logic [11:0]   t0_q, t0_d;
  logic [11:0]   t1_q, t1_d;
  logic [11:0]   canon;

  // Single conditional subtract: inputs at or above 2Q are reduced only once.
  assign canon = (coeff_in >= QV) ? coeff_in - QV : coeff_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pair_cnt_q <= '0;
      t0_q       <= '0;
      t1_q       <= '0;
    end else begin
      state_q    <= state_d;
      pair_cnt_q <= pair_cnt_d;
      t0_q       <= t0_d;
      t1_q       <= t1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pair_cnt_d = pair_cnt_q;
    t0_d       = t0_q;
    t1_d       = t1_q;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD0;
      LOAD0: if (coeff_valid) begin
        t0_d    = canon;
        state_d = LOAD1;
      end
      LOAD1: if (coeff_valid) begin
        t1_d    = canon;
        state_d = EMIT0;
      end
      EMIT0: if (byte_ready) state_d = EMIT1;
      EMIT1: if (byte_ready) state_d = EMIT2;
      EMIT2: if (byte_ready) begin
        if (pair_cnt_q == LAST_PAIR) begin
          pair_cnt_d = '0;
          state_d    = FIN;
        end else begin
          pair_cnt_d = pair_cnt_q + 1'b1;
          state_d    = LOAD0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state register only, so they cannot glitch on input changes.
  always_comb begin
    coeff_ready = (state_q == LOAD0) || (state_q == LOAD1);
    byte_valid  = (state_q == EMIT0) || (state_q == EMIT1) || (state_q == EMIT2);
    busy        = (state_q != IDLE);
    done        = (state_q == FIN);
    byte_out    = '0;
    unique case (state_q)
      EMIT0:   byte_out = t0_q[7:0];
      EMIT1:   byte_out = {t1_q[3:0], t0_q[11:8]};
      EMIT2:   byte_out = t1_q[11:4];
      default: byte_out = '0;
    endcase
  end

endmodule
